// File: rtl/etapa_busqueda_if.sv
// Instruction-fetch stage with IF/ID pipeline register and a one-entry skid buffer.
// Latency: a fetched word appears on instr one clock edge after the imem_valid cycle.
// Backpressure: stall holds the PC and IF/ID, and parks an in-flight word in the skid buffer (HOLD).
// Optional: define FETCH_PERF_CNT_EN to add the cnt_instr / cnt_stall performance counters.
module etapa_busqueda_if #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_id,
    output logic        instr_valid,
    output logic [19:0] inmediato,
    output logic        ImnSrc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] cnt_instr,
    output logic [31:0] cnt_stall
`endif
);

    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_id;
    logic        r_instr_valid;
    logic [31:0] r_skid_dat;
    logic [31:0] r_skid_pc;

    logic        w_fetch_ok;
    logic        w_load_valid;
    logic [31:0] w_branch_pc;

    // Redirect address is forced word-aligned.
    assign w_branch_pc = branch_target & 32'hFFFF_FFFC;

    // A memory response only counts while we are requesting and nothing higher-priority intervenes.
    assign w_fetch_ok   = (r_state == FETCH) && imem_valid && !branch_taken && !flush;

    // IF/ID receives a real instruction this cycle (either straight from memory or from the skid buffer).
    assign w_load_valid = !branch_taken && !flush && !stall &&
                          ((r_state == HOLD) || ((r_state == FETCH) && imem_valid));

    // The request drops immediately on reset or redirect; the new address goes out next cycle.
    assign imem_req  = (r_state == FETCH) && !reset && !branch_taken;
    assign imem_addr = r_pc;

    assign instr       = r_instr;
    assign pc_id       = r_pc_id;
    assign instr_valid = r_instr_valid;

    // Immediate field and upper-immediate select feed the sign extender with no extra latency.
    assign inmediato = r_instr[31:12];
    assign ImnSrc    = r_instr_valid &&
                       ((r_instr[6:0] == OP_LUI) || (r_instr[6:0] == OP_AUIPC));

    // Fetch FSM, PC, skid buffer and IF/ID register; priority is branch > flush > stall > normal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= FETCH;
            r_pc          <= PC_RESET;
            r_instr       <= NOP_INSTR;
            r_pc_id       <= 32'h0000_0000;
            r_instr_valid <= 1'b0;
            r_skid_dat    <= NOP_INSTR;
            r_skid_pc     <= 32'h0000_0000;
        end else if (branch_taken) begin
            r_state       <= FETCH;
            r_pc          <= w_branch_pc;
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_skid_dat    <= NOP_INSTR;
        end else if (flush) begin
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            if (r_state == HOLD) begin
                // The parked word is dropped, so step the PC back to refetch it.
                r_state    <= FETCH;
                r_pc       <= r_pc - 32'd4;
                r_skid_dat <= NOP_INSTR;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_fetch_ok) begin
                        r_pc <= r_pc + 32'd4;
                        if (stall) begin
                            r_skid_dat <= imem_rdata;
                            r_skid_pc  <= r_pc;
                            r_state    <= HOLD;
                        end else begin
                            r_instr       <= imem_rdata;
                            r_pc_id       <= r_pc;
                            r_instr_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        // Memory still busy: present a bubble downstream.
                        r_instr       <= NOP_INSTR;
                        r_instr_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        r_instr       <= r_skid_dat;
                        r_pc_id       <= r_skid_pc;
                        r_instr_valid <= 1'b1;
                        r_skid_dat    <= NOP_INSTR;
                        r_state       <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters: valid IF/ID loads and stalled cycles, both free-running with wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_instr <= 32'h0000_0000;
            cnt_stall <= 32'h0000_0000;
        end else begin
            if (w_load_valid) cnt_instr <= cnt_instr + 32'd1;
            if (stall)        cnt_stall <= cnt_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_etapa_busqueda_if.sv
// Directed bench for etapa_busqueda_if: reset, back-to-back fetch, latency, stall/skid,
// branch redirect, flush in HOLD and FETCH, PC wrap, and optional perf counters.
module tb_etapa_busqueda_if;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instr;
    logic [31:0] pc_id;
    logic        instr_valid;
    logic [19:0] inmediato;
    logic        ImnSrc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cnt_instr;
    logic [31:0] cnt_stall;
`endif

    int tests;
    int fails;

    etapa_busqueda_if dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .instr         (instr),
        .pc_id         (pc_id),
        .instr_valid   (instr_valid),
        .inmediato     (inmediato),
        .ImnSrc        (ImnSrc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .cnt_instr     (cnt_instr),
        .cnt_stall     (cnt_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall         = 1'b0;
        flush         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_rdata    = 32'h0;
        imem_valid    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Deliver one word on the current cycle with no stall.
    task automatic feed(input logic [31:0] w);
        imem_valid = 1'b1;
        imem_rdata = w;
        tick();
        imem_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h want 00000000", imem_addr); end
        tests++; if (instr !== 32'h0000_0013) begin fails++; $display("FAIL rst_instr: got %h want 00000013", instr); end
        tests++; if (pc_id !== 32'h0) begin fails++; $display("FAIL rst_pc_id: got %h want 00000000", pc_id); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        tests++; if (ImnSrc !== 1'b0) begin fails++; $display("FAIL rst_imnsrc: got %b want 0", ImnSrc); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        // Release reset with memory already answering on the first request cycle.
        reset      = 1'b1;
        clear_inputs();
        tick();
        reset      = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 32'h0000_02B7;
        #1;
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL b2b_req0: got %b want 1", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL b2b_addr0: got %h want 00000000", imem_addr); end
        tick();
        imem_rdata = 32'h0050_0093;
        #1;
        tests++; if (instr !== 32'h0000_02B7) begin fails++; $display("FAIL b2b_instr0: got %h want 000002b7", instr); end
        tests++; if (inmediato !== 20'h00000) begin fails++; $display("FAIL b2b_imm0: got %h want 00000", inmediato); end
        tests++; if (ImnSrc !== 1'b1) begin fails++; $display("FAIL b2b_imnsrc0: got %b want 1", ImnSrc); end
        tests++; if (imem_addr !== 32'h4) begin fails++; $display("FAIL b2b_addr1: got %h want 00000004", imem_addr); end
        tick();
        imem_valid = 1'b0;
        #1;
        tests++; if (instr !== 32'h0050_0093) begin fails++; $display("FAIL b2b_instr1: got %h want 00500093", instr); end
        tests++; if (ImnSrc !== 1'b0) begin fails++; $display("FAIL b2b_imnsrc1: got %b want 0", ImnSrc); end
        tests++; if (pc_id !== 32'h4) begin fails++; $display("FAIL b2b_pc_id1: got %h want 00000004", pc_id); end
        tests++; if (imem_addr !== 32'h8) begin fails++; $display("FAIL b2b_addr2: got %h want 00000008", imem_addr); end
    endtask

    task automatic test_latency();
        do_reset();
        feed(32'h0010_0093);
        // Two wait cycles, word on the third.
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin fails++; $display("FAIL lat_hold%0d: got addr %h req %b want 00000004 1", i, imem_addr, imem_req); end
            tests++; if (instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin fails++; $display("FAIL lat_bubble%0d: got %h v%b want 00000013 v0", i, instr, instr_valid); end
        end
        tests++; if (imem_addr !== 32'h4) begin fails++; $display("FAIL lat_addr3: got %h want 00000004", imem_addr); end
        feed(32'hABCD_E0B7);
        tests++; if (instr !== 32'hABCD_E0B7 || instr_valid !== 1'b1) begin fails++; $display("FAIL lat_load: got %h v%b want abcde0b7 v1", instr, instr_valid); end
        tests++; if (pc_id !== 32'h4) begin fails++; $display("FAIL lat_pc_id: got %h want 00000004", pc_id); end
        tests++; if (inmediato !== 20'hABCDE) begin fails++; $display("FAIL lat_imm: got %h want abcde", inmediato); end
        tests++; if (imem_addr !== 32'h8) begin fails++; $display("FAIL lat_next: got %h want 00000008", imem_addr); end
    endtask

    task automatic test_stall_hold();
        do_reset();
        feed(32'h0010_0093);
        feed(32'h0020_0113);
        // Word at pc 0x8 arrives while stalled: four stall cycles total.
        imem_valid = 1'b1;
        imem_rdata = 32'h1234_5037;
        stall      = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            // Stray response while not requesting must be ignored.
            imem_valid = (i == 1);
            imem_rdata = 32'hDEAD_BEEF;
            #1;
            tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL hold_req%0d: got %b want 0", i, imem_req); end
            tests++; if (instr !== 32'h0020_0113 || pc_id !== 32'h4) begin fails++; $display("FAIL hold_ifid%0d: got %h/%h want 00200113/00000004", i, instr, pc_id); end
            tick();
        end
        stall      = 1'b0;
        imem_valid = 1'b0;
        tick();
        tests++; if (instr !== 32'h1234_5037 || instr_valid !== 1'b1) begin fails++; $display("FAIL hold_out: got %h v%b want 12345037 v1", instr, instr_valid); end
        tests++; if (inmediato !== 20'h12345 || ImnSrc !== 1'b1) begin fails++; $display("FAIL hold_imm: got %h/%b want 12345/1", inmediato, ImnSrc); end
        tests++; if (pc_id !== 32'h8) begin fails++; $display("FAIL hold_pc_id: got %h want 00000008", pc_id); end
        tests++; if (imem_addr !== 32'hC || imem_req !== 1'b1) begin fails++; $display("FAIL hold_resume: got %h/%b want 0000000c/1", imem_addr, imem_req); end
    endtask

    task automatic test_branch();
        do_reset();
        feed(32'h0010_0093);
        feed(32'h0020_0113);
        feed(32'h0030_0193);
        tests++; if (imem_addr !== 32'hC) begin fails++; $display("FAIL br_pre: got %h want 0000000c", imem_addr); end
        imem_valid    = 1'b1;
        imem_rdata    = 32'h1111_1111;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        #1;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL br_req_drop: got %b want 0", imem_req); end
        tick();
        clear_inputs();
        #1;
        tests++; if (instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin fails++; $display("FAIL br_discard: got %h v%b want 00000013 v0", instr, instr_valid); end
        tests++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin fails++; $display("FAIL br_target: got %h/%b want 00000100/1", imem_addr, imem_req); end
    endtask

    task automatic test_flush();
        do_reset();
        feed(32'h0010_0093);
        imem_valid = 1'b1;
        imem_rdata = 32'h0000_5537;
        stall      = 1'b1;
        tick();
        imem_valid = 1'b0;
        flush      = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        #1;
        tests++; if (instr !== 32'h0000_0013 || instr_valid !== 1'b0) begin fails++; $display("FAIL fl_hold_bubble: got %h v%b want 00000013 v0", instr, instr_valid); end
        tests++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin fails++; $display("FAIL fl_hold_refetch: got %h/%b want 00000004/1", imem_addr, imem_req); end
        tick();
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL fl_skid_gone: got v%b want v0", instr_valid); end
        feed(32'h0000_5537);
        tests++; if (instr !== 32'h0000_5537 || pc_id !== 32'h4) begin fails++; $display("FAIL fl_reload: got %h/%h want 00005537/00000004", instr, pc_id); end
        // Flush in FETCH discards the same-cycle word without advancing.
        imem_valid = 1'b1;
        imem_rdata = 32'h2222_2222;
        flush      = 1'b1;
        tick();
        clear_inputs();
        #1;
        tests++; if (imem_addr !== 32'h8 || instr_valid !== 1'b0) begin fails++; $display("FAIL fl_fetch: got %h v%b want 00000008 v0", imem_addr, instr_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        #1;
        tests++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pre: got %h want fffffffc", imem_addr); end
        feed(32'h0000_0297);
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr: got %h want 00000000", imem_addr); end
        tests++; if (pc_id !== 32'hFFFF_FFFC || ImnSrc !== 1'b1) begin fails++; $display("FAIL wrap_ifid: got %h/%b want fffffffc/1", pc_id, ImnSrc); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        feed(32'h0010_0093);
        tick();
        // Asynchronous reset between clock edges during an outstanding request.
        #2;
        reset = 1'b1;
        #1;
        tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin fails++; $display("FAIL rstmid_req: got %b/%h want 0/00000000", imem_req, imem_addr); end
        tests++; if (instr !== 32'h0000_0013 || instr_valid !== 1'b0) begin fails++; $display("FAIL rstmid_ifid: got %h v%b want 00000013 v0", instr, instr_valid); end
        tick();
        reset = 1'b0;
        #1;
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_cnt();
        do_reset();
        feed(32'h0010_0093);
        feed(32'h0020_0113);
        stall = 1'b1;
        tick();
        tick();
        tick();
        stall = 1'b0;
        feed(32'h0030_0193);
        feed(32'h0040_0213);
        feed(32'h0050_0293);
        tests++; if (cnt_instr !== 32'd5) begin fails++; $display("FAIL perf_instr: got %0d want 5", cnt_instr); end
        tests++; if (cnt_stall !== 32'd3) begin fails++; $display("FAIL perf_stall: got %0d want 3", cnt_stall); end
        #2;
        reset = 1'b1;
        #1;
        tests++; if (cnt_instr !== 32'd0 || cnt_stall !== 32'd0) begin fails++; $display("FAIL perf_reset: got %0d/%0d want 0/0", cnt_instr, cnt_stall); end
        tick();
        reset = 1'b0;
        #1;
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_back_to_back();
        test_latency();
        test_stall_hold();
        test_branch();
        test_flush();
        test_wrap();
        test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/etapa_busqueda_if.md
Name: etapa_busqueda_if

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the microprocessor.
- Owns the PC and runs a request/valid handshake with instruction memory.
- Latches the fetched word and presents the immediate field (instr[31:12]) and the upper-immediate select to the downstream sign extender.
- Honours stall, flush and branch redirect from later stages.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) placed in IF/ID on reset/flush/empty cycles

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hold PC and IF/ID contents
flush  input  1  invalidate IF/ID (bubble)
branch_taken  input  1  redirect fetch this cycle
branch_target  input  32  redirect address
imem_addr  output  32  fetch address (= pc)
imem_req  output  1  fetch request
imem_rdata  input  32  fetched word, valid when imem_valid=1
imem_valid  input  1  memory response, only meaningful while imem_req=1, 1..N cycles after request
instr  output  32  IF/ID instruction
pc_id  output  32  PC of instr
instr_valid  output  1  instr is a real instruction
inmediato  output  20  instr[31:12], combinational from IF/ID
ImnSrc  output  1  1 when instr[6:0] is 7'b0110111 (LUI) or 7'b0010111 (AUIPC) and instr_valid=1; else 0

Behaviour:
- Clock and reset: one clock clk; reset asynchronous, active-high.
- Reset values:
  - pc=PC_RESET, state=FETCH.
  - imem_req=0 while reset is high; 1 on the first cycle after release.
  - instr=NOP_INSTR, pc_id=0, instr_valid=0, skid buffer empty.
- FSM states: FETCH, HOLD.
- FETCH:
  - imem_req=1, imem_addr=pc, held stable until imem_valid or redirect.
  - imem_valid=1 and stall=0: IF/ID <= {imem_rdata, pc}, instr_valid<=1, pc<=pc+4, stay in FETCH. Latency: word appears on instr the edge after imem_valid.
  - imem_valid=1 and stall=1: word goes to skid buffer, pc<=pc+4, go to HOLD. IF/ID unchanged.
  - imem_valid=0 and stall=0: IF/ID <= NOP_INSTR, instr_valid<=0.
  - imem_valid=0 and stall=1: IF/ID holds.
- HOLD:
  - imem_req=0.
  - When stall=0: IF/ID <= skid buffer, instr_valid<=1, buffer cleared, go to FETCH.
  - While stall=1: everything holds.
- Priority: reset > branch_taken > flush > stall > normal.
- branch_taken=1 (any state):
  - pc <= {branch_target[31:2],2'b00}.
  - IF/ID <= NOP_INSTR, instr_valid<=0.
  - Skid buffer cleared; a same-cycle imem_valid is discarded; state<=FETCH.
  - imem_req drops for that cycle. The new address is issued the next cycle.
- flush=1 without branch:
  - IF/ID <= bubble.
  - Same-cycle imem_valid word is discarded and pc is NOT advanced (refetch).
  - In HOLD, the skid buffer is discarded, pc <= pc-4 and state goes to FETCH.
- stall and flush together: flush wins.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- Reset mid-transaction: outstanding request is abandoned; any later imem_valid while imem_req=0 is ignored.
- inmediato and ImnSrc are purely combinational from the IF/ID register; no added latency.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs cnt_instr[31:0] (increments on every IF/ID load with instr_valid<=1).
  - Adds cnt_stall[31:0] (increments every cycle stall=1 and reset=0).
  - Both reset to 0 asynchronously and wrap at 2^32.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory returns imem_valid the same cycle with words 0x000002B7, 0x00500093 -> imem_addr 0x0,0x4,0x8. Next cycle instr=0x000002B7, inmediato=0x00000, ImnSrc=1; following cycle instr=0x00500093, ImnSrc=0.
- Memory latency 3 cycles -> imem_addr held at 0x4 for 3 cycles, instr_valid=0 with instr=0x00000013 during the wait, then the word loads, pc_id=0x4.
- stall raised on the imem_valid cycle for word 0x12345037 at pc 0x8, held 4 cycles -> state HOLD, imem_req=0, IF/ID unchanged. One cycle after stall drops: instr=0x12345037, inmediato=0x12345, ImnSrc=1, pc_id=0x8.
- branch_taken with target 0x00000103 while a fetch of 0xC is pending and imem_valid=1 -> word discarded, instr_valid=0, next imem_addr=0x00000100.
- flush and stall together in HOLD -> bubble in IF/ID, skid buffer discarded, refetch of the same address. Separately: pc=0xFFFFFFFC fetch -> next imem_addr=0x00000000.
- (FETCH_PERF_CNT_EN) 5 fetched instructions and 3 stall cycles -> cnt_instr=5, cnt_stall=3. Asserting reset mid-run -> both 0 immediately.
